// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
//   Request/response bundle for the iterative shift sequencer.
//   Request side : in_valid, in_ready, in_data, in_amt, in_type
//   Response side: out_valid, out_ready, out_data
//   Status       : busy
//   master = issuer/consumer side, slave = sequencer side.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] in_amt;
  logic [2:0]       in_type;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_type, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_type, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle shift sequencer. Accepts one shift op through the request
//   handshake, shifts a working register a few bits per cycle, then presents
//   the result through the response handshake until it is taken.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : shift_seq_ctrl_if.slave
//          in_valid/in_ready/in_data/in_amt/in_type  request
//          out_valid/out_ready/out_data              response
//          busy                                      high in SHIFT or DONE
// Shift types: 000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR,
//              110/111 reserved (result 0).
// Configuration
//   SHIFT_FAST_EN : when defined, up to 4 bits are shifted per cycle
//                   (results unchanged, fewer SHIFT cycles).
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    T_LSL  = 3'b000,
    T_LSR  = 3'b001,
    T_ASL  = 3'b010,
    T_ASR  = 3'b011,
    T_ROL  = 3'b100,
    T_ROR  = 3'b101,
    T_RSV6 = 3'b110,
    T_RSV7 = 3'b111
  } shift_type_e;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e            state_q, state_d;
  shift_type_e       type_q,  type_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [CNT_W-1:0]  eff;
  logic              rsv;
  logic [CNT_W-1:0]  step_n;
  logic [WIDTH-1:0]  work;

  // One 1-bit step of the given shift type.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d,
                                             input shift_type_e t);
    logic [WIDTH-1:0] r;
    r = d;
    case (t)
      T_LSL, T_ASL: r = {d[WIDTH-2:0], 1'b0};
      T_LSR:        r = {1'b0, d[WIDTH-1:1]};
      T_ASR:        r = {d[WIDTH-1], d[WIDTH-1:1]};
      T_ROL:        r = {d[WIDTH-2:0], d[WIDTH-1]};
      T_ROR:        r = {d[0], d[WIDTH-1:1]};
      default:      r = d;
    endcase
    return r;
  endfunction

  // Effective step count for the incoming request. Linear shifts saturate
  // at WIDTH (all bits shifted out / all sign copies); rotates wrap.
  always_comb begin
    eff = '0;
    rsv = 1'b0;
    case (shift_type_e'(bus.in_type))
      T_LSL, T_LSR, T_ASL, T_ASR:
        eff = (bus.in_amt >= WIDTH_V) ? CNT_W'(WIDTH) : CNT_W'(bus.in_amt);
      T_ROL, T_ROR:
        eff = CNT_W'(bus.in_amt % WIDTH_V);
      default: begin
        eff = '0;
        rsv = 1'b1;
      end
    endcase
  end

  // Per-cycle datapath step.
  always_comb begin
    step_n = '0;
    work   = data_q;
`ifdef SHIFT_FAST_EN
    step_n = (cnt_q > CNT_W'(4)) ? CNT_W'(4) : cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (CNT_W'(i) < step_n) work = step1(work, type_q);
    end
`else
    step_n = CNT_W'(1);
    work   = step1(data_q, type_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          type_d  = shift_type_e'(bus.in_type);
          data_d  = rsv ? '0 : bus.in_data;
          cnt_d   = eff;
          state_d = (eff == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = work;
        cnt_d  = cnt_q - step_n;
        if (cnt_q <= step_n) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= T_LSL;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
//   Directed bench for shift_seq_ctrl. Latency is counted in clock edges
//   including the accept edge (eff=0 -> out_valid visible right after the
//   accept edge = 1 edge).
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;

  shift_seq_ctrl_if #(.WIDTH(16)) bus ();

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  t;
    logic [15:0] d;
    logic [15:0] a;
    logic [15:0] exp;
    int          eff;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int eff);
`ifdef SHIFT_FAST_EN
    return (eff + 3) / 4 + 1;
`else
    return eff + 1;
`endif
  endfunction

  // Drive a request and return #1 after the accept edge; inputs are
  // scrambled afterwards to show they are not sampled again.
  task automatic issue(input logic [2:0] t, input logic [15:0] d, input logic [15:0] a);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in_data  = d;
    bus.in_amt   = a;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_type  = ~t;
    bus.in_data  = ~d;
    bus.in_amt   = a + 16'd7;
  endtask

  // Called #1 after the accept edge; waits (bounded) for out_valid.
  task automatic wait_result(input string name, input int exp_lat, input logic [15:0] exp_d);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " out_data"}, bus.out_data, exp_d);
    chk({name, " in_ready in DONE"}, bus.in_ready, 1'b0);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " out_valid after take"}, bus.out_valid, 1'b0);
    chk({name, " in_ready after take"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"lsl1_3",   3'b000, 16'h0001, 16'd3,      16'h0008, 3};
    vecs[1]  = '{"asr_20",   3'b011, 16'h8000, 16'd20,     16'hFFFF, 16};
    vecs[2]  = '{"ror_17",   3'b101, 16'h0001, 16'd17,     16'h8000, 1};
    vecs[3]  = '{"lsr_0",    3'b001, 16'hABCD, 16'd0,      16'hABCD, 0};
    vecs[4]  = '{"rsv110",   3'b110, 16'h1234, 16'd5,      16'h0000, 0};
    vecs[5]  = '{"lsr_15",   3'b001, 16'h8000, 16'd15,     16'h0001, 15};
    vecs[6]  = '{"rol_4",    3'b100, 16'h8001, 16'd4,      16'h0018, 4};
    vecs[7]  = '{"asl_8",    3'b010, 16'h00FF, 16'd8,      16'hFF00, 8};
    vecs[8]  = '{"lsl_16",   3'b000, 16'hFFFF, 16'd16,     16'h0000, 16};
    vecs[9]  = '{"asr_pos",  3'b011, 16'h4000, 16'd100,    16'h0000, 16};
    vecs[10] = '{"rol_16",   3'b100, 16'h1234, 16'd16,     16'h1234, 0};
    vecs[11] = '{"asr_2",    3'b011, 16'h8421, 16'd2,      16'hE108, 2};
    vecs[12] = '{"rsv111",   3'b111, 16'hFFFF, 16'd0,      16'h0000, 0};
    vecs[13] = '{"ror_6",    3'b101, 16'h00F0, 16'd6,      16'hC003, 6};
    vecs[14] = '{"lsr_max",  3'b001, 16'hABCD, 16'hFFFF,   16'h0000, 16};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_type   = 3'b000;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  bus.in_ready,  1'b1);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset out_data",  bus.out_data,  16'h0000);
    chk("reset busy",      bus.busy,      1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven ops.
    foreach (vecs[i]) begin
      issue(vecs[i].t, vecs[i].d, vecs[i].a);
      wait_result(vecs[i].name, lat_of(vecs[i].eff), vecs[i].exp);
      handshake(vecs[i].name);
    end

    // DONE stall: result held, new request ignored, no same-cycle re-accept.
    issue(3'b000, 16'h0001, 16'd3);
    wait_result("stall", lat_of(3), 16'h0008);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_type  = 3'b101;
    bus.in_data  = 16'h0001;
    bus.in_amt   = 16'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid", bus.out_valid, 1'b1);
      chk("stall out_data",  bus.out_data,  16'h0008);
      chk("stall in_ready",  bus.in_ready,  1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("take out_valid", bus.out_valid, 1'b0);
    chk("take in_ready",  bus.in_ready,  1'b1);
    chk("take busy",      bus.busy,      1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk);   // pending request is accepted here
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hFFFF;
    chk("reaccept busy",     bus.busy,     1'b1);
    chk("reaccept in_ready", bus.in_ready, 1'b0);
    wait_result("reaccept", lat_of(1), 16'h8000);
    handshake("reaccept");

    // Reset mid-SHIFT.
    issue(3'b000, 16'h00FF, 16'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("midshift busy", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst shift in_ready",  bus.in_ready,  1'b1);
    chk("rst shift out_valid", bus.out_valid, 1'b0);
    chk("rst shift out_data",  bus.out_data,  16'h0000);
    chk("rst shift busy",      bus.busy,      1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      chk("rst shift no out_valid", seen, 1'b0);
    end

    // Reset mid-DONE.
    issue(3'b001, 16'h5A5A, 16'd0);
    chk("middone out_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst done out_valid", bus.out_valid, 1'b0);
    chk("rst done out_data",  bus.out_data,  16'h0000);
    chk("rst done in_ready",  bus.in_ready,  1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Fresh op after reset still works.
    issue(3'b100, 16'h8000, 16'd1);
    wait_result("post rst rol", lat_of(1), 16'h0001);
    handshake("post rst rol");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
